seg7_anim_sequencer: RTL and testbench
======================================

// Module: seg7_anim_sequencer
// PURPOSE
//   Drives the counter[3:0] and animation[2:0] inputs of the seg7 decoder.
//   - Prescales clk into a step tick; steps the frame counter through the active animation's length.
//   - Debounces a push button that cycles the animation select 0 -> 1 -> 2 -> 0.
//   - Sits directly upstream of seg7. All outputs are registered.
// PARAMETERS
//   TICK_DIV         10_000_000  clk cycles per step at speed=0; must be >= 8
//   DEBOUNCE_CYCLES  100_000     consecutive stable cycles to accept a button level; must be >= 2
// PORTS
//   clk        in   1  system clock; single clock domain
//   rst_n      in   1  asynchronous, active-low reset
//   ena        in   1  global enable; low freezes the block (see BEHAVIOUR)
//   btn_next   in   1  raw, asynchronous, active-high push button; advances the animation
//   pause      in   1  high holds the frame counter and the prescaler
//   speed      in   2  step period = TICK_DIV >> speed cycles
//   counter    out  4  frame index to seg7
//   animation  out  3  animation select to seg7; only 0..2 are ever driven
//   tick       out  1  one-cycle pulse in the cycle the counter steps
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - counter=0, animation=0, tick=0, prescaler=0.
//     - Synchronizer flops=0, debounced level=0, debounce count=0, FSM=IDLE.
//   Frame lengths (LEN)
//     - anim0: 10 (0..9); anim1: 7 (0..6); anim2: 7 (0..6).
//     - counter never leaves 0..LEN-1.
//   Prescaler
//     - PERIOD = TICK_DIV >> speed, computed in 32 bits.
//     - Each enabled, un-paused cycle: if prescaler >= PERIOD-1, set tick=1 and prescaler=0; else prescaler+1.
//     - The >= compare handles speed raised mid-count: the tick fires on the next cycle.
//     - After reset, speed=0: first tick registered TICK_DIV cycles after rst_n releases.
//   Step
//     - On tick, counter = (counter==LEN-1) ? 0 : counter+1.
//     - Registered in the same edge as tick; 1 cycle latency from prescaler terminal count.
//   Button path
//     - 2-flop synchronizer feeds debounce counter and a 1-bit stable level.
//     - Count increments while synced != stable; it clears on any cycle they match.
//     - When count reaches DEBOUNCE_CYCLES-1, stable takes the synced value and count clears.
//   Button FSM (states: IDLE, HELD)
//     - IDLE -> HELD on stable 0->1; emits adv for exactly one cycle.
//     - HELD -> IDLE on stable 1->0.
//     - One advance per press, regardless of hold time.
//   Advance (adv)
//     - animation = (animation==2) ? 0 : animation+1.
//     - counter=0, prescaler=0, tick forced 0 that cycle.
//   Timing
//     - Clean press: animation changes DEBOUNCE_CYCLES+3 cycles after btn_next is first sampled high.
//     - Glitch shorter than DEBOUNCE_CYCLES synced cycles: no effect.
//   Simultaneous events
//     - adv and prescaler terminal count in the same cycle: adv wins, no step.
//   pause=1
//     - Prescaler, counter held; tick=0.
//     - Button path and advances remain active.
//   ena=0
//     - Prescaler, counter, animation, debounce count and FSM all held; tick=0, no adv.
//     - Synchronizer keeps sampling.
//   Reset mid-operation
//     - All state returns to reset values immediately, independent of clk.
//     - A press in progress is discarded.
// TESTING (TICK_DIV=8, DEBOUNCE_CYCLES=4, ena=1 unless stated)
//   1. Release reset, speed=0 -> tick every 8 cycles, first 8 cycles after release; counter 0..9 then 0 on the 10th tick.
//   2. btn_next high 12 cycles -> exactly one advance 7 cycles after first sample; animation=1, counter=0.
//      Then counter wraps 6->0 on the 7th tick.
//   3. btn_next high 3 cycles, then low -> animation and counter unchanged.
//   4. Three clean presses from anim0 -> animation 1, 2, 0; counter=0 after each.
//   5. speed=3 -> tick every cycle. pause=1 for 20 cycles -> counter frozen, tick=0.
//      pause=0 -> counter steps next cycle. Press aligned with terminal count -> advance, no step.
//   6. rst_n low mid-count with animation=2 and button held -> all outputs 0 immediately.
//      Held button yields an advance only after release-free re-debounce.

Source files
------------

// File: rtl/seg7_anim_sequencer.sv
// Frame/animation sequencer feeding the seg7 decoder: prescaled step tick,
// debounced "next animation" button, all outputs registered.
module seg7_anim_sequencer #(
    parameter int unsigned TICK_DIV        = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_next,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic [3:0] counter,
    output logic [2:0] animation,
    output logic       tick
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]    TICK_DIV32 = 32'(TICK_DIV);

    typedef enum logic {
        IDLE,
        HELD
    } btn_state_t;

    logic [1:0]     sync;
    logic           stable;
    logic [DBW-1:0] db_cnt;
    btn_state_t     state;
    logic           adv;
    logic [31:0]    presc;
    logic [31:0]    period_m1;
    logic [3:0]     last_frame;

    // Raising speed mid-count is safe: the >= compare below fires on the next cycle.
    always_comb begin
        period_m1  = (TICK_DIV32 >> speed) - 32'd1;
        last_frame = (animation == 3'd0) ? 4'd9 : 4'd6;
    end

    // The synchronizer samples even when ena is low so no stale level is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn_next};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (ena) begin
            if (sync[1] != stable) begin
                if (db_cnt == DB_LAST) begin
                    stable <= sync[1];
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // adv is held along with the FSM while ena is low, so a pending advance is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            adv   <= 1'b0;
        end else if (ena) begin
            adv <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable) begin
                        state <= HELD;
                        adv   <= 1'b1;
                    end
                end
                HELD: begin
                    if (!stable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // An advance outranks a prescaler terminal count in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= 4'd0;
            animation <= 3'd0;
            tick      <= 1'b0;
            presc     <= 32'd0;
        end else if (ena) begin
            if (adv) begin
                animation <= (animation == 3'd2) ? 3'd0 : animation + 3'd1;
                counter   <= 4'd0;
                presc     <= 32'd0;
                tick      <= 1'b0;
            end else if (pause) begin
                tick <= 1'b0;
            end else if (presc >= period_m1) begin
                tick    <= 1'b1;
                presc   <= 32'd0;
                counter <= (counter == last_frame) ? 4'd0 : counter + 4'd1;
            end else begin
                tick  <= 1'b0;
                presc <= presc + 32'd1;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_anim_sequencer.sv
// Bench for seg7_anim_sequencer: directed stimulus pushes expected output events
// (cycle, animation, counter, tick) into a queue; a monitor pops and compares.
module tb_seg7_anim_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       btn_next;
    logic       pause;
    logic [1:0] speed;
    logic [3:0] counter;
    logic [2:0] animation;
    logic       tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    logic [23:0] exp_q[$];
    logic [2:0]  last_anim;
    logic [3:0]  last_cnt;

    seg7_anim_sequencer #(
        .TICK_DIV       (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .btn_next (btn_next),
        .pause    (pause),
        .speed    (speed),
        .counter  (counter),
        .animation(animation),
        .tick     (tick)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] ev(input int c, input int a, input int cnt, input int t);
        return {16'(c), 3'(a), 4'(cnt), 1'(t)};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cyc=%0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain_check(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // driver: reset with given speed/pause, verify reset values, release on a negedge
    task automatic do_reset(input logic [1:0] spd, input logic pse);
        @(negedge clk);
        rst_n    = 1'b0;
        ena      = 1'b1;
        btn_next = 1'b0;
        pause    = pse;
        speed    = spd;
        repeat (2) @(negedge clk);
        check("reset_counter", int'(counter), 0);
        check("reset_animation", int'(animation), 0);
        check("reset_tick", int'(tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            last_anim <= animation;
            last_cnt  <= counter;
        end else if (tick || animation != last_anim || counter != last_cnt) begin
            logic [23:0] got;
            logic [23:0] exp;
            got = {16'(cyc), animation, counter, tick};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got cyc=%0d anim=%0d cnt=%0d tick=%0d",
                         cyc, animation, counter, tick);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL event got cyc=%0d anim=%0d cnt=%0d tick=%0d expected cyc=%0d anim=%0d cnt=%0d tick=%0d",
                             got[23:8], got[7:5], got[4:1], got[0],
                             exp[23:8], exp[7:5], exp[4:1], exp[0]);
                end
            end
            last_anim <= animation;
            last_cnt  <= counter;
        end
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        btn_next  = 1'b0;
        pause     = 1'b0;
        speed     = 2'd0;
        last_anim = 3'd0;
        last_cnt  = 4'd0;

        // 1: free-running steps through anim0, wrap on the 10th tick
        do_reset(2'd0, 1'b0);
        for (int k = 1; k <= 10; k++) exp_q.push_back(ev(base + 8 * k, 0, k % 10, 1));
        wait_until(base + 86);
        drain_check("t1_drain");

        // 2: long press -> single advance 7 cycles after first sample, anim1 wraps at 7
        do_reset(2'd0, 1'b0);
        exp_q.push_back(ev(base + 8, 0, 1, 1));
        exp_q.push_back(ev(base + 10, 1, 0, 0));
        for (int j = 1; j <= 7; j++) exp_q.push_back(ev(base + 10 + 8 * j, 1, j % 7, 1));
        wait_until(base + 2);
        btn_next = 1'b1;
        wait_until(base + 14);
        btn_next = 1'b0;
        wait_until(base + 72);
        drain_check("t2_drain");

        // 3: 3-cycle glitch is ignored
        do_reset(2'd0, 1'b0);
        for (int k = 1; k <= 3; k++) exp_q.push_back(ev(base + 8 * k, 0, k, 1));
        wait_until(base + 2);
        btn_next = 1'b1;
        wait_until(base + 5);
        btn_next = 1'b0;
        wait_until(base + 30);
        drain_check("t3_drain");

        // 4: three presses while paused -> anim 1, 2, 0 with counter cleared
        do_reset(2'd0, 1'b0);
        exp_q.push_back(ev(base + 8, 0, 1, 1));
        for (int p = 0; p < 3; p++) exp_q.push_back(ev(base + 18 + 20 * p, (p + 1) % 3, 0, 0));
        wait_until(base + 8);
        pause = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wait_until(base + 10 + 20 * p);
            btn_next = 1'b1;
            wait_until(base + 18 + 20 * p);
            btn_next = 1'b0;
        end
        wait_until(base + 75);
        drain_check("t4_drain");

        // 5: speed=3 ticks every cycle, pause freezes, advance beats terminal count
        do_reset(2'd3, 1'b0);
        for (int k = 1; k <= 5; k++) exp_q.push_back(ev(base + k, 0, k, 1));
        for (int k = 26; k <= 32; k++) exp_q.push_back(ev(base + k, 0, (k - 20) % 10, 1));
        exp_q.push_back(ev(base + 33, 1, 0, 0));
        for (int j = 1; j <= 12; j++) exp_q.push_back(ev(base + 33 + j, 1, j % 7, 1));
        wait_until(base + 5);
        pause = 1'b1;
        wait_until(base + 25);
        pause    = 1'b0;
        btn_next = 1'b1;
        wait_until(base + 35);
        btn_next = 1'b0;
        wait_until(base + 45);
        pause = 1'b1;
        wait_until(base + 60);
        drain_check("t5_drain");

        // 6: async reset mid-count at anim2 with button held, then re-debounce
        do_reset(2'd0, 1'b0);
        exp_q.push_back(ev(base + 8, 0, 1, 1));
        exp_q.push_back(ev(base + 9, 1, 0, 0));
        exp_q.push_back(ev(base + 17, 1, 1, 1));
        exp_q.push_back(ev(base + 25, 1, 2, 1));
        exp_q.push_back(ev(base + 28, 2, 0, 0));
        exp_q.push_back(ev(base + 36, 2, 1, 1));
        exp_q.push_back(ev(base + 44, 2, 2, 1));
        wait_until(base + 1);
        btn_next = 1'b1;
        wait_until(base + 9);
        btn_next = 1'b0;
        wait_until(base + 20);
        btn_next = 1'b1;
        wait_until(base + 46);
        drain_check("t6_pre_reset_drain");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_counter", int'(counter), 0);
        check("t6_async_animation", int'(animation), 0);
        check("t6_async_tick", int'(tick), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        exp_q.push_back(ev(base + 8, 1, 0, 0));
        exp_q.push_back(ev(base + 16, 1, 1, 1));
        wait_until(base + 10);
        btn_next = 1'b0;
        wait_until(base + 22);
        drain_check("t6_post_reset_drain");

        // 7: ena low for 10 cycles delays the prescaler by 10
        do_reset(2'd0, 1'b0);
        exp_q.push_back(ev(base + 18, 0, 1, 1));
        exp_q.push_back(ev(base + 26, 0, 2, 1));
        wait_until(base + 3);
        ena = 1'b0;
        wait_until(base + 13);
        ena = 1'b1;
        wait_until(base + 30);
        drain_check("t7_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
